// File: rtl/coeff_input_register.sv
// coeff_input_register: double-buffered coefficient store; the host fills a shadow bank,
// and a commit copies it into the active bank read by the MAC.
module coeff_input_register #(
    parameter int COEFF_W    = 16,
    parameter int NUM_COEFFS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enable,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [COEFF_W-1:0] i_wr_data,
    input  logic               i_coeffs_en,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [COEFF_W-1:0] o_rd_data,
    output logic               o_write_done,
    output logic               o_wr_reject,
    output logic               o_coeff_valid
);
    localparam int IW = $clog2(NUM_COEFFS);
    localparam logic [ADDR_W:0] NUM_L = (ADDR_W+1)'(NUM_COEFFS);
    typedef enum logic {FILL = 1'b0, PENDING = 1'b1} state_t;
    state_t state_q, state_d;
    logic [COEFF_W-1:0] shadow_q [NUM_COEFFS];
    logic [COEFF_W-1:0] active_q [NUM_COEFFS];
    logic [NUM_COEFFS-1:0] mask_q, mask_d;
    logic [COEFF_W-1:0] rd_data_q, rd_data_d;
    logic reject_q, reject_d, valid_q, valid_d;
    logic wr_ok, commit;
    logic [IW-1:0] wa, ra;
    always_comb begin
        wa = i_wr_addr[IW-1:0];
        ra = i_rd_addr[IW-1:0];
        wr_ok = i_wr_en && ({1'b0, i_wr_addr} < NUM_L) && state_q == FILL;
        commit = i_coeffs_en && state_q == PENDING;
        reject_d = i_wr_en && !wr_ok;
        valid_d = valid_q || commit;
        rd_data_d = ({1'b0, i_rd_addr} < NUM_L) ? active_q[ra] : '0;
        mask_d = mask_q;
        state_d = state_q;
        if (commit) begin
            mask_d = '0;
            state_d = FILL;
        end else if (wr_ok) begin
            mask_d[wa] = 1'b1;
            state_d = &mask_d ? PENDING : FILL;
        end
    end
    // Everything, including the read register and reject pulse, freezes while clk_enable is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FILL;
            mask_q    <= '0;
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            rd_data_q <= '0;
            reject_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            rd_data_q <= rd_data_d;
            reject_q  <= reject_d;
            valid_q   <= valid_d;
            if (wr_ok) shadow_q[wa] <= i_wr_data;
            if (commit) active_q <= shadow_q;
        end
    end
    assign o_write_done  = state_q == PENDING;
    assign o_rd_data     = rd_data_q;
    assign o_wr_reject   = reject_q;
    assign o_coeff_valid = valid_q;
endmodule

// File: doc/coeff_input_register.md
# coeff_input_register

Double-buffered coefficient store feeding the equalizer's filter datapath. A host writes 16-bit coefficient words into a shadow bank. Once every address has been written, the block raises `o_write_done`, which is the level consumed by the write-done capture stage. When the capture stage returns `i_coeffs_en` at the phase-63 boundary, the shadow bank is committed atomically into the active bank that the MAC reads. Filtering therefore never sees a half-updated coefficient set.

## Interface
- `COEFF_W`, default 16: coefficient word width.
- `NUM_COEFFS`, default 64: number of coefficients, 8 bands × 8 taps.
- `ADDR_W`, default 6: address width. Must satisfy 2^ADDR_W ≥ NUM_COEFFS.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `clk_enable`  in  1  when 0, all state holds, including the read register.
- `i_wr_en`  in  1  host write strobe, one word per enabled cycle.
- `i_wr_addr`  in  ADDR_W  host write address.
- `i_wr_data`  in  COEFF_W  host write data, signed two's complement, stored verbatim.
- `i_coeffs_en`  in  1  commit request from write-done capture (phase_63 & capture).
- `i_rd_addr`  in  ADDR_W  active-bank read address from the phase counter.
- `o_rd_data`  out  COEFF_W  registered active-bank read data.
- `o_write_done`  out  1  level: shadow bank complete, commit pending.
- `o_wr_reject`  out  1  one-cycle pulse: a write was dropped.
- `o_coeff_valid`  out  1  sticky: at least one commit since reset.

## Operation
- **State**
  - Shadow bank: `NUM_COEFFS × COEFF_W`.
  - Active bank: `NUM_COEFFS × COEFF_W`.
  - Written mask: `NUM_COEFFS` bits.
  - Registers: `o_write_done`, `o_rd_data`, `o_wr_reject`, `o_coeff_valid`.
- **Reset** (`rst`=0, asynchronous):
  - Both banks, the mask and every output go to 0.
  - `o_rd_data`=0, `o_write_done`=0, `o_wr_reject`=0, `o_coeff_valid`=0.
  - Reset mid-fill discards the partial shadow contents.
- **Two-state control**: FILL (`o_write_done`=0) and PENDING (`o_write_done`=1).
- **FILL**
  - A write with `i_wr_en`=1 and `i_wr_addr` < `NUM_COEFFS` stores the data and sets `mask[addr]`.
  - Rewriting an address overwrites the data; the mask bit is already set.
  - When the mask becomes all-ones, the next state is PENDING (`o_write_done`←1).
- **PENDING**
  - All writes are dropped. `o_wr_reject` pulses for one enabled cycle per dropped write.
  - `o_write_done` holds high until commit.
  - `i_coeffs_en`=1 performs the commit:
    - active ← shadow, all words in the same edge;
    - mask ← 0;
    - `o_write_done` ← 0;
    - `o_coeff_valid` ← 1;
    - next state is FILL.
  - Shadow contents are retained after commit.
- **`i_coeffs_en` in FILL**: ignored, no state change. The capture stage never asserts it there.
- **Out-of-range write** (`addr` ≥ `NUM_COEFFS`): dropped, `o_wr_reject` pulses, in either state.
- **Read path**: `o_rd_data` ← `active[i_rd_addr]` every enabled cycle. An out-of-range `i_rd_addr` returns 0.
- **`clk_enable`=0**: no write, commit, read or pulse takes effect. Inputs presented in that cycle are lost.

## Timing
- **Write**: accepted at enabled edge N. The last missing word at edge N gives `o_write_done`=1 from edge N onward (0 cycles after acceptance).
- **Commit**: `i_coeffs_en` sampled at enabled edge M. The active bank holds new data and `o_write_done`=0 after edge M.
- **Read latency**: 1 enabled cycle.
  - A read at the commit edge M returns the pre-commit value.
  - A read at M+1 returns the new value.
- **Write and commit at the same edge**: the write is evaluated against PENDING, so it is rejected. The commit proceeds. The host must retry that write.
- `o_wr_reject` is high for exactly the enabled cycle following the dropped write.
- **Downstream capture**: it edge-detects `o_write_done` rising. `o_write_done` must therefore be glitch-free and register-driven, never combinational.

## Test plan
- **Reset**: hold `rst`=0 with random inputs, then release → all outputs 0; reading addresses 0..63 returns 0.
- **Fill and commit**:
  - Write `addr k` = `16'h1000+k` for k=0..63, then pulse `i_coeffs_en` → `o_write_done` rises on the 64th write and falls after the commit edge.
  - Reading `addr 5` returns `16'h1005` one cycle after the commit edge.
  - `o_coeff_valid`=1.
- **Partial fill and overwrite**:
  - Write addresses 0..62, writing address 10 twice (`16'hAAAA` then `16'h5555`) → `o_write_done` stays 0.
  - Then write address 63 → `o_write_done`=1.
  - After commit, `addr 10` reads `16'h5555`.
- **Reject cases**:
  - A write to address 64 (`NUM_COEFFS`=64, `ADDR_W`=7 build) → `o_wr_reject` pulses.
  - A write while PENDING → `o_wr_reject` pulses and that address is unchanged after commit.
  - A write at the same edge as the commit → rejected.
- **`clk_enable` gating**: the 64th write issued with `clk_enable`=0 → no `o_write_done`. Repeating it with `clk_enable`=1 → `o_write_done`=1.
- **Reset mid-operation**:
  - Assert `rst` while PENDING → `o_write_done`=0 immediately (asynchronous) and the active bank is 0.
  - A subsequent single commit without a full refill is impossible: `i_coeffs_en` in FILL is ignored.
